// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the IF-stage program-counter generator.
//   pcg_state_e  - generator FSM states (post-reset hold, running)
//   redir_src_e  - origin of a buffered redirect (branch or trap)
//   align_pc()   - clears the low alignment bits of a redirect target
package pc_gen_pkg;

  typedef enum logic {
    PCG_HOLD = 1'b0,
    PCG_RUN  = 1'b1
  } pcg_state_e;

  typedef enum logic {
    SRC_BR   = 1'b0,
    SRC_TRAP = 1'b1
  } redir_src_e;

  // Widest PC the helper handles; callers zero-extend in and truncate out.
  localparam int unsigned PCG_MAX_XLEN = 64;

  function automatic logic [PCG_MAX_XLEN-1:0] align_pc(
    input logic [PCG_MAX_XLEN-1:0] addr,
    input int unsigned             align_bits
  );
    logic [PCG_MAX_XLEN-1:0] mask;
    mask = '1;
    mask = mask << align_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_gen_unit_redirect_buf.sv
// pc_redirect_buf: one-entry buffer holding a redirect that arrived while
// the pipeline was stalled.
//   clk, rst_n         - clock, async active-low reset
//   capture_i          - store src_i/target_i this edge
//   src_i, target_i    - source and (already aligned) target of the redirect
//   clear_i            - drop the entry (wins over capture)
//   valid_o, src_o,
//   target_o           - registered buffer contents
// A branch never replaces a buffered trap; anything else overwrites.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture_i,
  input  redir_src_e      src_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            clear_i,
  output logic            valid_o,
  output redir_src_e      src_o,
  output logic [XLEN-1:0] target_o
);

  logic            valid_q, valid_d;
  redir_src_e      src_q,   src_d;
  logic [XLEN-1:0] tgt_q,   tgt_d;
  logic            keep_trap;

  assign keep_trap = valid_q && (src_q == SRC_TRAP) && (src_i == SRC_BR);

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    tgt_d   = tgt_q;
    if (clear_i) begin
      valid_d = 1'b0;
      src_d   = SRC_BR;
      tgt_d   = '0;
    end else if (capture_i && !keep_trap) begin
      valid_d = 1'b1;
      src_d   = src_i;
      tgt_d   = target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_q   <= SRC_BR;
      tgt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      tgt_q   <= tgt_d;
    end
  end

  assign valid_o  = valid_q;
  assign src_o    = src_q;
  assign target_o = tgt_q;

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program-counter generator for the IF stage.
//   clk, rst_n          - clock, async active-low reset
//   stall               - hold pc this cycle (redirects get buffered)
//   trap_valid/trap_pc  - trap redirect, highest priority
//   br_valid/br_pc      - branch/jump redirect from EX
//   pc                  - registered fetch address
//   pc_next_seq         - pc + 2**ALIGN_BITS (wraps)
//   fetch_valid         - registered, 1 once the post-reset hold is over
//   pending_valid       - registered, 1 while a redirect is buffered
// After reset the FSM sits in HOLD for RESET_HOLD_CYCLES edges with pc at
// RESET_VECTOR, ignoring all inputs, then runs until the next reset.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN              = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR      = '0,
  parameter int unsigned     RESET_HOLD_CYCLES = 1,
  parameter int unsigned     ALIGN_BITS        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            fetch_valid,
  output logic            pending_valid
);

  localparam int unsigned     CNT_W     = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD_CYCLES);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(1) << ALIGN_BITS;

  pcg_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q;

  logic [XLEN-1:0] trap_tgt, br_tgt, redir_tgt;
  redir_src_e      redir_src;
  logic            in_run, buf_capture, buf_clear;
  logic            pend_valid;
  redir_src_e      pend_src_unused;
  logic [XLEN-1:0] pend_tgt;

  assign trap_tgt = XLEN'(align_pc(PCG_MAX_XLEN'(trap_pc), ALIGN_BITS));
  assign br_tgt   = XLEN'(align_pc(PCG_MAX_XLEN'(br_pc),   ALIGN_BITS));

  // Same-cycle trap and branch: the trap is the one that gets captured.
  assign redir_tgt = trap_valid ? trap_tgt : br_tgt;
  assign redir_src = trap_valid ? SRC_TRAP : SRC_BR;

  assign in_run      = (state_q == PCG_RUN);
  assign buf_capture = in_run && stall && (trap_valid || br_valid);
  // Any unstalled RUN edge either consumes the entry or supersedes it
  // with a fresh redirect, so the buffer is always emptied then.
  assign buf_clear   = in_run && !stall;

  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (buf_capture),
    .src_i     (redir_src),
    .target_i  (redir_tgt),
    .clear_i   (buf_clear),
    .valid_o   (pend_valid),
    .src_o     (pend_src_unused), // only the buffer's overwrite rule needs it
    .target_o  (pend_tgt)
  );

  assign pc_next_seq = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (trap_valid)      pc_d = trap_tgt;
      else if (br_valid)   pc_d = br_tgt;
      else if (pend_valid) pc_d = pend_tgt;
      else                 pc_d = pc_next_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PCG_HOLD;
      cnt_q   <= HOLD_INIT;
      pc_q    <= RESET_VECTOR;
      fv_q    <= 1'b0;
    end else begin
      case (state_q)
        PCG_HOLD: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= PCG_RUN;
            fv_q    <= 1'b1;
          end
        end
        PCG_RUN: begin
          pc_q <= pc_d;
          fv_q <= 1'b1;
        end
        default: begin
          state_q <= PCG_HOLD;
          cnt_q   <= HOLD_INIT;
          pc_q    <= RESET_VECTOR;
          fv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign fetch_valid   = fv_q;
  assign pending_valid = pend_valid;

endmodule
